// File: rtl/pdfd_dfe_lanes.sv
// Multi-lane PAM-5 decision-feedback slicer with double-buffered taps, a 1-deep output register and a fill/lock flag.
// Optional slicer error output: define PDFD_DFE_ERR_OUT_EN to add out_err.
module pdfd_dfe_lanes #(
  parameter int LANES    = 4,
  parameter int TAPS     = 4,
  parameter int SAMPLE_W = 8,
  parameter int TAP_W    = 8,
  parameter int LEVEL    = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*SAMPLE_W-1:0]      in_samples,
  input  logic                           tap_load,
  input  logic [LANES*TAPS*TAP_W-1:0]    tap_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*3-1:0]             out_dec,
`ifdef PDFD_DFE_ERR_OUT_EN
  output logic [LANES*SAMPLE_W-1:0]      out_err,
`endif
  output logic                           locked
);

  localparam int ACC_W = SAMPLE_W + TAP_W + $clog2(TAPS) + 2;
  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic signed [ACC_W-1:0] H1  = ACC_W'(LEVEL / 2);
  localparam logic signed [ACC_W-1:0] H3  = ACC_W'(3 * (LEVEL / 2));
  localparam logic signed [ACC_W-1:0] NH1 = ACC_W'(-(LEVEL / 2));
  localparam logic signed [ACC_W-1:0] NH3 = ACC_W'(-3 * (LEVEL / 2));

  logic signed [TAP_W-1:0] tap_act [LANES][TAPS];
  logic signed [TAP_W-1:0] tap_sh  [LANES][TAPS];
  logic                    tap_pend;
  // hist[l][k] holds a[n-1-k] for lane l.
  logic signed [2:0]       hist    [LANES][TAPS];
  logic [CNT_W-1:0]        fill_cnt;

  logic signed [ACC_W-1:0] y       [LANES];
  logic signed [2:0]       dec_nxt [LANES];
  logic                    accept;

  // Handshake: a transfer happens on any rising edge where valid && ready.
  // The output register frees itself on the same edge it drains, so input
  // readiness only depends on the output side.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign locked   = (fill_cnt == CNT_W'(TAPS));

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      y[l] = ACC_W'($signed(in_samples[l*SAMPLE_W +: SAMPLE_W]));
      for (int k = 0; k < TAPS; k++) begin
        y[l] = y[l] - ACC_W'(tap_act[l][k]) * ACC_W'(hist[l][k]);
      end
      // Strict upper compares and inclusive lower compares resolve ties toward zero.
      if (y[l] > H3)        dec_nxt[l] = 3'sd2;
      else if (y[l] > H1)   dec_nxt[l] = 3'sd1;
      else if (y[l] >= NH1) dec_nxt[l] = 3'sd0;
      else if (y[l] >= NH3) dec_nxt[l] = 3'b111;
      else                  dec_nxt[l] = 3'b110;
    end
  end

`ifdef PDFD_DFE_ERR_OUT_EN
  localparam logic signed [ACC_W-1:0] LVL  = ACC_W'(LEVEL);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(1 << (SAMPLE_W - 1)));

  logic signed [ACC_W-1:0]    e_full  [LANES];
  logic signed [SAMPLE_W-1:0] err_nxt [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      e_full[l] = y[l] - ACC_W'(dec_nxt[l]) * LVL;
      if (e_full[l] > SMAX)      err_nxt[l] = SMAX[SAMPLE_W-1:0];
      else if (e_full[l] < SMIN) err_nxt[l] = SMIN[SAMPLE_W-1:0];
      else                       err_nxt[l] = e_full[l][SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_err <= '0;
    end else if (accept) begin
      for (int l = 0; l < LANES; l++) out_err[l*SAMPLE_W +: SAMPLE_W] <= err_nxt[l];
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_dec   <= '0;
      fill_cnt  <= '0;
      tap_pend  <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < TAPS; k++) begin
          hist[l][k]    <= '0;
          tap_act[l][k] <= '0;
          tap_sh[l][k]  <= '0;
        end
      end
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        for (int l = 0; l < LANES; l++) begin
          out_dec[l*3 +: 3] <= dec_nxt[l];
          hist[l][0]        <= dec_nxt[l];
          for (int k = 1; k < TAPS; k++) hist[l][k] <= hist[l][k-1];
        end
        if (fill_cnt != CNT_W'(TAPS)) fill_cnt <= fill_cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A load on an accept edge defers the bank swap to the next accept.
      if (tap_load) begin
        tap_pend <= 1'b1;
        for (int l = 0; l < LANES; l++) begin
          for (int k = 0; k < TAPS; k++) begin
            tap_sh[l][k] <= tap_data[(l*TAPS + k)*TAP_W +: TAP_W];
          end
        end
      end else if (accept && tap_pend) begin
        tap_pend <= 1'b0;
        for (int l = 0; l < LANES; l++) begin
          for (int k = 0; k < TAPS; k++) tap_act[l][k] <= tap_sh[l][k];
        end
      end
    end
  end

endmodule
